// File: rtl/mem_req_tracker_if.sv
// ---------------------------------------------------------------------------
// mem_pkg / memory
//
// Shared types for the tagged memory bus and the bus interface itself.
//
// memory #(DEPTH) signals:
//   qry_cmd  : mem_cmd_t  query command (NONE when no query is offered)
//   qry_idx  : mem_idx_t  block index of the query
//   qry_blk  : mem_blk_t  store data of the query
//   ack      : tag        non-zero tag when memory takes the query
//   ans_blk  : mem_blk_t  data of a load answer
//   ans_tag  : tag        non-zero tag of the load being answered
// Modports: dev (client side) and mem (memory side).
// ---------------------------------------------------------------------------
package mem_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } mem_cmd_t;

  typedef logic [12:0] mem_idx_t;
  typedef logic [63:0] mem_blk_t;
  typedef logic [3:0]  mem_tag_t;
endpackage

interface memory #(
  parameter int DEPTH = 15
);
  // Tag 0 is reserved for "nothing", so DEPTH tags need one extra code point.
  localparam int TAG_W = $clog2(DEPTH + 1);

  mem_pkg::mem_cmd_t qry_cmd;
  mem_pkg::mem_idx_t qry_idx;
  mem_pkg::mem_blk_t qry_blk;
  logic [TAG_W-1:0]  ack;
  mem_pkg::mem_blk_t ans_blk;
  logic [TAG_W-1:0]  ans_tag;

  modport dev (
    output qry_cmd, qry_idx, qry_blk,
    input  ack, ans_blk, ans_tag
  );

  modport mem (
    input  qry_cmd, qry_idx, qry_blk,
    output ack, ans_blk, ans_tag
  );
endinterface

// File: rtl/mem_req_tracker.sv
// ---------------------------------------------------------------------------
// mem_req_tracker
//
// Client-side front end for the tagged memory bus. Takes one load/store per
// cycle from the client, holds it on the bus until memory acks it with a
// non-zero tag, records tag -> index for loads, and returns each tagged
// answer to the client with its block index.
//
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready    : client request handshake
//   req_cmd/req_idx/req_blk: request command, block index, store data
//   rsp_valid/idx/blk      : one-cycle load response (no backpressure)
//   outstanding            : number of valid tag-table entries
//   tag_err                : sticky protocol-violation flag
//   mem                    : memory.dev bus port
// ---------------------------------------------------------------------------
module mem_req_tracker
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_cmd_t    req_cmd,
  input  mem_idx_t    req_idx,
  input  mem_blk_t    req_blk,
  output logic        rsp_valid,
  output mem_idx_t    rsp_idx,
  output mem_blk_t    rsp_blk,
  output logic [3:0]  outstanding,
  output logic        tag_err,
  memory.dev          mem
);

  localparam int NUM_TAGS = 15;

  logic        hold_valid_q, hold_valid_d;
  mem_cmd_t    hold_cmd_q, hold_cmd_d;
  mem_idx_t    hold_idx_q, hold_idx_d;
  mem_blk_t    hold_blk_q, hold_blk_d;

  logic [NUM_TAGS-1:0] tbl_valid_q, tbl_valid_d;
  mem_idx_t            tbl_idx_q [NUM_TAGS];
  mem_idx_t            tbl_idx_d [NUM_TAGS];

  logic        rsp_valid_q, rsp_valid_d;
  mem_idx_t    rsp_idx_q, rsp_idx_d;
  mem_blk_t    rsp_blk_q, rsp_blk_d;
  logic        tag_err_q, tag_err_d;

  mem_tag_t    ack_tag;
  mem_tag_t    ans_tag;
  logic [3:0]  ack_slot;
  logic [3:0]  ans_slot;
  logic [3:0]  valid_count;
  logic [4:0]  inflight;
  logic        hold_is_load;
  logic        hold_release;
  logic        accept;

  assign ack_tag  = mem.ack;
  assign ans_tag  = mem.ans_tag;
  // Table entry for tag t lives at slot t-1; only used when the tag is non-zero.
  assign ack_slot = ack_tag - 4'd1;
  assign ans_slot = ans_tag - 4'd1;

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      valid_count = valid_count + {3'b000, tbl_valid_q[i]};
    end
  end

  // A held load counts against the cap too, so an ack of it never overflows.
  assign hold_is_load = hold_valid_q && (hold_cmd_q == BUS_LOAD);
  assign inflight     = {1'b0, valid_count} + {4'b0000, hold_is_load};
  assign hold_release = hold_valid_q && (ack_tag != '0);
  assign req_ready    = (!hold_valid_q || (ack_tag != '0)) &&
                        (inflight < 5'(MAX_OUTSTANDING));
  assign accept       = req_valid && req_ready && (req_cmd != BUS_NONE);

  // Answer is processed before the ack so a tag freed and re-allocated in
  // the same cycle returns the old index and is not flagged as a collision.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_cmd_d   = hold_cmd_q;
    hold_idx_d   = hold_idx_q;
    hold_blk_d   = hold_blk_q;
    tbl_valid_d  = tbl_valid_q;
    tbl_idx_d    = tbl_idx_q;
    rsp_valid_d  = 1'b0;
    rsp_idx_d    = rsp_idx_q;
    rsp_blk_d    = rsp_blk_q;
    tag_err_d    = tag_err_q;

    if (ans_tag != '0) begin
      if (tbl_valid_q[ans_slot]) begin
        tbl_valid_d[ans_slot] = 1'b0;
        rsp_valid_d           = 1'b1;
        rsp_idx_d             = tbl_idx_q[ans_slot];
        rsp_blk_d             = mem.ans_blk;
      end else begin
        tag_err_d = 1'b1;
      end
    end

    if (hold_release && (hold_cmd_q == BUS_LOAD)) begin
      if (tbl_valid_d[ack_slot]) begin
        tag_err_d = 1'b1;
      end
      tbl_valid_d[ack_slot] = 1'b1;
      tbl_idx_d[ack_slot]   = hold_idx_q;
    end

    // Idle hold is zeroed so the bus shows NONE/0 without extra gating.
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_cmd_d   = req_cmd;
      hold_idx_d   = req_idx;
      hold_blk_d   = req_blk;
    end else if (hold_release) begin
      hold_valid_d = 1'b0;
      hold_cmd_d   = BUS_NONE;
      hold_idx_d   = '0;
      hold_blk_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_cmd_q   <= BUS_NONE;
      hold_idx_q   <= '0;
      hold_blk_q   <= '0;
      tbl_valid_q  <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        tbl_idx_q[i] <= '0;
      end
      rsp_valid_q  <= 1'b0;
      rsp_idx_q    <= '0;
      rsp_blk_q    <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_cmd_q   <= hold_cmd_d;
      hold_idx_q   <= hold_idx_d;
      hold_blk_q   <= hold_blk_d;
      tbl_valid_q  <= tbl_valid_d;
      tbl_idx_q    <= tbl_idx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_blk_q    <= rsp_blk_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign mem.qry_cmd = hold_cmd_q;
  assign mem.qry_idx = hold_idx_q;
  assign mem.qry_blk = hold_blk_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_idx     = rsp_idx_q;
  assign rsp_blk     = rsp_blk_q;
  assign outstanding = valid_count;
  assign tag_err     = tag_err_q;

endmodule

// File: doc/mem_req_tracker.md
# mem_req_tracker

Client-side front end for the tagged memory bus; it drives the `dev` side of the memory interface. It accepts one load or store per cycle from a cache/fetch client and holds each query on the bus until memory acknowledges it with a non-zero tag. For loads, it records the tag-to-index mapping and matches each later tagged answer back to its block index, returning the block to the client.

## Interface
- MAX_OUTSTANDING, default 15: cap on loads in flight, counting the held query plus table entries; legal range 1..15.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  client offers a request.
- req_ready  out  1  tracker accepts the request this cycle.
- req_cmd  in  mem_cmd_t (2)  BUS_LOAD=1 or BUS_STORE=2; BUS_NONE=0 with req_valid is ignored and not accepted.
- req_idx  in  mem_idx_t (13)  block index.
- req_blk  in  mem_blk_t (64)  store data; don't-care for loads.
- rsp_valid  out  1  one-cycle pulse; a load block is returned.
- rsp_idx  out  mem_idx_t (13)  index of the returned block.
- rsp_blk  out  mem_blk_t (64)  returned data.
- outstanding  out  4  number of valid tag-table entries.
- tag_err  out  1  sticky; set by a protocol violation, cleared only by reset.
- mem  memory.dev  modport (DEPTH=15): drives qry_cmd/qry_blk/qry_idx; samples ack, ans_blk, ans_tag.
- mem_tag_t is 4 bits. Tag 0 means "not accepted" on ack and "no answer" on ans_tag.

## Operation
- Holding register `hold` (valid, cmd, idx, blk) drives `qry_*` directly. When hold is invalid, qry_cmd=BUS_NONE and qry_idx/qry_blk=0.
- Tag table: 15 entries indexed by tag-1, each {valid, idx}.
- Acceptance: req_ready = (!hold.valid || ack!=0) && (inflight < MAX_OUTSTANDING). Here inflight = outstanding + (hold.valid && hold.cmd==LOAD).
  - req_ready depends combinationally on `ack`; there is no other combinational path from inputs to outputs.
  - On req_valid && req_ready && cmd!=NONE, hold loads the request at the edge.
- Issue: while hold.valid, the query stays on the bus unchanged until a cycle with ack!=0. At that edge:
  - Hold clears, unless it is refilled by a new request in the same cycle.
  - If the held query was a LOAD, table[ack] is set to {1, hold.idx}.
  - If table[ack] was already valid and is not freed by an answer in the same cycle, set tag_err and overwrite the entry.
- STORE retires on ack; no answer is expected.
- Answer: when ans_tag!=0:
  - If table[ans_tag] is valid, clear it and register rsp_valid=1, rsp_idx=entry.idx, rsp_blk=ans_blk for the next cycle.
  - If it is invalid, drop the answer and set tag_err.
- The response path has no backpressure. The client must accept rsp every cycle.
- Simultaneous events, same tag on ack and ans_tag in one cycle: the answer frees the old entry first (using the old idx), then the ack allocates the new entry. tag_err is not set.
- outstanding = popcount(table.valid). It changes at the edge: +1 on a load ack, -1 on a matched answer; net 0 when both happen.

## Timing
- Reset values:
  - hold.valid=0, qry_cmd=BUS_NONE, qry_idx=0, qry_blk=0.
  - All table entries invalid.
  - rsp_valid=0, rsp_idx=0, rsp_blk=0, outstanding=0, tag_err=0.
  - req_ready=1 once reset deasserts.
- Request to qry visible: 1 cycle, registered.
- Throughput: one query per cycle when memory acks every cycle.
- Answer to rsp: ans_tag in cycle N gives rsp_valid in cycle N+1.
- Stall: while ack==0 with hold valid, qry_* must be stable cycle to cycle and req_ready=0.
- Cap: with MAX_OUTSTANDING loads in flight, req_ready=0 even if ack!=0. The held query is still released on ack.
- Reset mid-operation clears all state immediately. Answers that arrive after reset deasserts find invalid entries: they are dropped and set tag_err. The bench treats this as expected.

## Test plan
- Single load: req LOAD idx=0x0A5, then ack=3 on the first qry cycle, then ans_tag=3 with ans_blk=0xDEADBEEF_CAFEF00D five cycles later. Required: rsp_valid one cycle later with rsp_idx=0x0A5 and that blk; outstanding goes 0,1,0.
- Stall: hold ack=0 for 4 cycles with a LOAD pending. Required: qry_* stable, req_ready=0 for 4 cycles; the entry is allocated on the 5th cycle's ack=7.
- Back-to-back: 4 stores then 4 loads, each acked immediately with tags 1..8. Required: 8 consecutive qry cycles, outstanding=4; out-of-order answers 8,5,7,6 return the matching idx each.
- Same-cycle reuse: tag 2 outstanding for idx=0x010, with ans_tag=2 and ack=2 for a new load idx=0x020 in the same cycle. Required: rsp_idx=0x010, table[2].idx=0x020, tag_err=0.
- Cap: MAX_OUTSTANDING=2, two loads acked and unanswered, third request offered. Required: req_ready=0 until the first answer, then accepted the next cycle.
- Errors/reset: ans_tag=9 with no entry. Required: no rsp, tag_err=1. Then assert reset mid-stall. Required: all outputs return to their reset values asynchronously.
